dbus_arbiter_n: RTL
===================

DBUS_ARBITER_N -- requirements
Module: dbus_arbiter_n

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of bus masters (2..8).
REQ-002 Parameter AW, default 32: address width.
REQ-003 Parameter DW, default 32: data width; byte-mask width DW/8.
REQ-004 Parameter TIMEOUT, default 255: wait-cycle limit used only under DBUS_ARB_TIMEOUT_EN.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 addrM  in  NUM_MASTERS*AW  per-master address, master i at slice [i*AW +: AW].
REQ-008 doutM  in  NUM_MASTERS*DW  per-master write data.
REQ-009 dmM  in  NUM_MASTERS*DW/8  per-master byte write mask; all-zero means read.
REQ-010 stbM  in  NUM_MASTERS  per-master request strobe.
REQ-011 dinM  out  DW  read data, shared by all masters.
REQ-012 nakM  out  NUM_MASTERS  per-master wait: 1 = not done, 0 = transfer completes this cycle.
REQ-013 addrS/dinS/dmS/stbS  out  AW/DW/DW/8/1  slave request (dinS is write data to slave).
REQ-014 doutS  in  DW  slave read data; nakS  in  1  slave wait.
REQ-015 grant  out  clog2(NUM_MASTERS)  index of the current owner, for debug.
REQ-016 err  out  1  one-cycle timeout pulse (constant 0 without the macro).

Function
REQ-017 States: IDLE and BUSY, plus a registered grant index and a round-robin pointer ptr.
- IDLE, any stbM bit set: grant <= first requesting index at or after ptr, searching upward with wrap.
- In that case, state <= BUSY on the next edge.
REQ-018 In IDLE: stbS=0, and nakM is all-ones for every master.
REQ-019 In BUSY, slave outputs are driven from the granted master's slices.
- stbS = stbM[grant].
- nakM[grant] = nakS; every other nakM bit = 1.
REQ-020 dinM = doutS in every state (combinational pass-through).
REQ-021 A transfer completes in a BUSY cycle with stbS=1 and nakS=0; on that edge, ptr <= grant+1 (mod NUM_MASTERS) and state <= IDLE.
REQ-022 BUSY with stbM[grant]=0 (master abort): state <= IDLE, and ptr is unchanged.
REQ-023 Arbitration latency is exactly 1 cycle: stb rises at cycle n, so stbS is first high at cycle n+1.
- Minimum per-transfer latency is 2 cycles when nakS=0.
REQ-024 Simultaneous requests are served in round-robin order; no master waits more than NUM_MASTERS-1 transfers.
REQ-025 Grant is never changed while in BUSY.
- A new request arriving in BUSY waits.
- A completion and a new request in the same cycle re-arbitrate on the next IDLE cycle.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, grant=0, ptr=0, err=0, timeout counter=0.
- Consequently stbS=0 and nakM all-ones.
REQ-027 rst asserted mid-BUSY aborts the transfer with no completion; after release, arbitration restarts from ptr=0.

Configuration
REQ-028 Macro DBUS_ARB_TIMEOUT_EN.
REQ-029 When defined: a counter tracks consecutive BUSY cycles with stbS=1 and nakS=1.
- When the count reaches TIMEOUT, that cycle forces nakM[grant]=0, dinM=32'hDEAD_BEEF (DW bits, zero-extended/truncated) and err=1.
- On the following edge, the FSM completes as in REQ-021.
- The counter clears on every completion and on leaving BUSY.
REQ-030 When undefined: no counter exists, err is tied to 0, and a stalled slave holds the bus indefinitely.

Verification
REQ-031 Single master: stbM=4'b0001, addr 0x1000, nakS=0.
- stbS high in cycle 1; nakM[0]=0 in cycle 1; grant=0; ptr becomes 1.
REQ-032 Contention: stbM=4'b1111 held, nakS=0.
- Grants in order 0,1,2,3,0, each transfer 2 cycles.
- Ungranted nakM bits stay 1 throughout.
REQ-033 Wait states: master 2 reads, nakS high for 3 cycles then low, doutS=0x12345678.
- nakM[2]=1 for 3 BUSY cycles, then 0 with dinM=0x12345678.
- Master 1 requesting meanwhile is not granted until after.
REQ-034 Abort: master 1 granted, drops stb in BUSY before nakS falls.
- Returns to IDLE; ptr stays; master 1 rerequests and is granted again ahead of master 2.
REQ-035 Reset mid-transfer: rst pulsed while BUSY with grant=3.
- stbS=0 immediately (asynchronous); grant=0 and ptr=0 after release.
REQ-036 Timeout (macro defined, TIMEOUT=4): nakS stuck at 1.
- In the 4th wait cycle: err=1 for one cycle, nakM[grant]=0, dinM=0xDEADBEEF.
- Then IDLE; without the macro, nakM[grant] stays 1.

Source files
------------

// File: rtl/dbus_arbiter_n.sv
// dbus_arbiter_n: round-robin arbiter that funnels NUM_MASTERS request
// ports onto a single slave port. The FSM has two states, IDLE and BUSY.
// Once a master is granted, it keeps the bus until its transfer
// completes or it drops its strobe.
//
// Optional feature, controlled by macro DBUS_ARB_TIMEOUT_EN:
// a stalled slave is cut off after TIMEOUT consecutive wait cycles.
// In that cycle the arbiter returns 32'hDEAD_BEEF and pulses err.
//
// state | meaning
// IDLE  | no owner; pick the next requester at or after ptr
// BUSY  | grant owns the slave port until completion or abort
module dbus_arbiter_n #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*AW-1:0]       addrM,
    input  logic [NUM_MASTERS*DW-1:0]       doutM,
    input  logic [NUM_MASTERS*DW/8-1:0]     dmM,
    input  logic [NUM_MASTERS-1:0]          stbM,
    output logic [DW-1:0]                   dinM,
    output logic [NUM_MASTERS-1:0]          nakM,
    output logic [AW-1:0]                   addrS,
    output logic [DW-1:0]                   dinS,
    output logic [DW/8-1:0]                 dmS,
    output logic                            stbS,
    input  logic [DW-1:0]                   doutS,
    input  logic                            nakS,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant,
    output logic                            err
);

    localparam int GW = $clog2(NUM_MASTERS);
    localparam int MW = DW / 8;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_param_check
        $error("dbus_arbiter_n: NUM_MASTERS must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]   pick;
    logic            pick_found;
    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-1:0]   req_rot;
    logic [GW:0]     idx_sum;
    logic            sel_stb;
    logic            timeout_hit;
    logic            xfer_done;

    assign grant = grant_q;

    // Route the granted master's request fields onto the slave port.
    always_comb begin
        addrS   = '0;
        dinS    = '0;
        dmS     = '0;
        sel_stb = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == GW'(i)) begin
                addrS   = addrM[i*AW +: AW];
                dinS    = doutM[i*DW +: DW];
                dmS     = dmM[i*MW +: MW];
                sel_stb = stbM[i];
            end
        end
    end

    assign stbS      = (state_q == BUSY) && sel_stb;
    assign xfer_done = stbS && (!nakS || timeout_hit);

    // Only the owner sees the slave wait; everyone else is held off.
    always_comb begin
        nakM = '1;
        if (state_q == BUSY) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (grant_q == GW'(i)) begin
                    nakM[i] = nakS && !timeout_hit;
                end
            end
        end
    end

    // Round-robin pick: rotate requests so that ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl    = {stbM, stbM} >> ptr_q;
        req_rot    = req_dbl[NUM_MASTERS-1:0];
        pick       = '0;
        pick_found = 1'b0;
        idx_sum    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!pick_found && req_rot[i]) begin
                idx_sum = {1'b0, ptr_q} + (GW+1)'(i);
                if (idx_sum >= (GW+1)'(NUM_MASTERS)) begin
                    idx_sum = idx_sum - (GW+1)'(NUM_MASTERS);
                end
                pick       = idx_sum[GW-1:0];
                pick_found = 1'b1;
            end
        end
    end

    // Next-state logic: the grant is frozen in BUSY, and ptr advances only on completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|stbM) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!sel_stb) begin
                    state_d = IDLE;
                end else if (xfer_done) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == GW'(NUM_MASTERS-1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef DBUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] DEAD_WORD = DW'(32'hDEAD_BEEF);

    logic [TW-1:0] wait_q;

    // The timeout fires on the TIMEOUT-th consecutive wait cycle, so it compares against one less.
    assign timeout_hit = stbS && nakS && (wait_q == TW'(TIMEOUT - 1));

    // Count consecutive stalled cycles; clear on completion, on abort, or on leaving BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (stbS && nakS && !timeout_hit) begin
            wait_q <= wait_q + 1'b1;
        end else begin
            wait_q <= '0;
        end
    end

    assign err  = timeout_hit;
    assign dinM = timeout_hit ? DEAD_WORD : doutS;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
    assign dinM        = doutS;
`endif

endmodule
